// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
// Accepts a length-prefixed (16-bit word count, little-endian) byte stream
// over valid/ready, assembles 32-bit words LSB first and issues one write
// per word. The core is held in reset until a complete image is in memory.
// Optional feature macro: LOADER_CHECKSUM_EN adds an XOR checksum trailer
// byte that must match all data bytes before the load is declared done.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  // Word counter is one bit wider than the address so a full memory
  // (N = 2^ADDR_WIDTH) can be counted without wrapping.
  localparam int          CW  = ADDR_WIDTH + 1;
  localparam logic [16:0] CAP = 17'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    S_CHK    = 3'd5,
`endif
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  // State entered once all words are written (or N = 0).
`ifdef LOADER_CHECKSUM_EN
  localparam state_t END_ST = S_CHK;
`else
  localparam state_t END_ST = S_DONE;
`endif

  state_t                  state_r;
  state_t                  state_nx_s;
  logic                    byte_ready_r;
  logic                    imem_we_r;
  logic [ADDR_WIDTH-1:0]   imem_addr_r;
  logic [31:0]             imem_wdata_r;
  logic                    cpu_hold_r;
  logic                    done_r;
  logic                    error_r;
  logic [7:0]              len_lo_r;
  logic [CW-1:0]           n_r;
  logic [CW-1:0]           cnt_r;
  logic [1:0]              lane_r;
  logic [7:0]              b0_r;
  logic [7:0]              b1_r;
  logic [7:0]              b2_r;
  logic                    xfer_s;
  logic                    start_ok_s;
  logic                    last_word_s;
  logic [16:0]             len_s;
  logic                    len_big_s;
  logic                    len_zero_s;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]              csum_r;

  // Running XOR checksum over data bytes.
  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  // States in which the loader consumes a stream byte.
  function automatic logic ready_in(input state_t s);
    logic r;
    case (s)
      S_LEN_LO: r = 1'b1;
      S_LEN_HI: r = 1'b1;
      S_DATA:   r = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:    r = 1'b1;
`endif
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

  // byte_ready is a register, so the handshake never combines with byte_valid.
  assign xfer_s      = byte_valid & byte_ready_r;
  assign start_ok_s  = start & ((state_r == S_IDLE) | (state_r == S_DONE) | (state_r == S_ERR));
  assign last_word_s = ((cnt_r + CW'(1)) == n_r);
  assign len_s       = {1'b0, byte_data, len_lo_r};
  assign len_big_s   = (len_s > CAP);
  assign len_zero_s  = (len_s == 17'd0);

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_nx_s = S_LEN_LO;
        end else begin
          state_nx_s = state_r;
        end
      end
      S_LEN_LO: begin
        if (xfer_s) begin
          state_nx_s = S_LEN_HI;
        end else begin
          state_nx_s = S_LEN_LO;
        end
      end
      S_LEN_HI: begin
        if (!xfer_s) begin
          state_nx_s = S_LEN_HI;
        end else if (len_big_s) begin
          state_nx_s = S_ERR;
        end else if (len_zero_s) begin
          state_nx_s = END_ST;
        end else begin
          state_nx_s = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer_s && (lane_r == 2'd3)) begin
          state_nx_s = S_WRITE;
        end else begin
          state_nx_s = S_DATA;
        end
      end
      S_WRITE: begin
        if (last_word_s) begin
          state_nx_s = END_ST;
        end else begin
          state_nx_s = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (!xfer_s) begin
          state_nx_s = S_CHK;
        end else if (byte_data == csum_r) begin
          state_nx_s = S_DONE;
        end else begin
          state_nx_s = S_ERR;
        end
      end
`endif
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State register and outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      byte_ready_r <= 1'b0;
      imem_we_r    <= 1'b0;
      cpu_hold_r   <= 1'b1;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      byte_ready_r <= ready_in(state_nx_s);
      imem_we_r    <= (state_nx_s == S_WRITE);
      cpu_hold_r   <= (state_nx_s != S_DONE);
      done_r       <= (state_nx_s == S_DONE);
      error_r      <= (state_nx_s == S_ERR);
    end
  end

  // Length capture, byte-lane assembly, word/address counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo_r     <= 8'h00;
      n_r          <= '0;
      cnt_r        <= '0;
      lane_r       <= 2'd0;
      b0_r         <= 8'h00;
      b1_r         <= 8'h00;
      b2_r         <= 8'h00;
      imem_addr_r  <= '0;
      imem_wdata_r <= 32'h0000_0000;
`ifdef LOADER_CHECKSUM_EN
      csum_r       <= 8'h00;
`endif
    end else if (start_ok_s) begin
      lane_r      <= 2'd0;
      cnt_r       <= '0;
      imem_addr_r <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_r      <= 8'h00;
`endif
    end else begin
      case (state_r)
        S_LEN_LO: begin
          if (xfer_s) begin
            len_lo_r <= byte_data;
          end
        end
        S_LEN_HI: begin
          if (xfer_s) begin
            n_r <= len_s[CW-1:0];
          end
        end
        S_DATA: begin
          if (xfer_s) begin
            lane_r <= lane_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_r <= csum_next(csum_r, byte_data);
`endif
            case (lane_r)
              2'd0:    b0_r <= byte_data;
              2'd1:    b1_r <= byte_data;
              2'd2:    b2_r <= byte_data;
              default: imem_wdata_r <= {byte_data, b2_r, b1_r, b0_r};
            endcase
          end
        end
        S_WRITE: begin
          // Address stays on the last word so it never wraps on a full load.
          cnt_r <= cnt_r + CW'(1);
          if (!last_word_s) begin
            imem_addr_r <= imem_addr_r + ADDR_WIDTH'(1);
          end
        end
        default: begin
          lane_r <= lane_r;
        end
      endcase
    end
  end

  assign byte_ready = byte_ready_r;
  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign cpu_hold   = cpu_hold_r;
  assign done       = done_r;
  assign error      = error_r;

endmodule
